// File: rtl/dtc_pkg.sv
// Shared definitions for the decision-tree preimage search engine:
// widths, FSM state encoding and the response record.
package dtc_pkg;

    localparam int FEAT_W = 12;
    localparam int CLS_W  = 3;

    // Probe count reached when every vector of the space has been compared.
    localparam logic [FEAT_W:0] SPACE_CNT = {1'b1, {FEAT_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic              found;
        logic [FEAT_W-1:0] vec;
        logic [FEAT_W:0]   probes;
    } rsp_t;

endpackage

// File: rtl/dtc_preimage_search_if.sv
// Host-side request/response port of the preimage search engine.
interface dtc_preimage_search_if;
    import dtc_pkg::*;

    logic              req_valid_i;
    logic              req_ready_o;
    logic [CLS_W-1:0]  req_class_i;
    logic [FEAT_W-1:0] req_start_i;
    logic              abort_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic              rsp_found_o;
    logic [FEAT_W-1:0] rsp_vec_o;
    logic [FEAT_W:0]   rsp_probes_o;

    // Host side: issues requests, consumes responses.
    modport master (
        output req_valid_i, req_class_i, req_start_i, abort_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_found_o, rsp_vec_o, rsp_probes_o
    );

    // Engine side.
    modport slave (
        input  req_valid_i, req_class_i, req_start_i, abort_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_found_o, rsp_vec_o, rsp_probes_o
    );

endinterface

// File: rtl/dtc_preimage_search.sv
// Sweeps feature vectors through an external combinational classifier,
// one per cycle, until one maps to the requested class or the whole
// vector space has been probed.
module dtc_preimage_search
    import dtc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    dtc_preimage_search_if.slave  bus,
    output logic [FEAT_W-1:0]     probe_o,
    input  logic [CLS_W-1:0]      probe_class_i,
    output logic                  busy_o
);

    state_e            state_q, state_d;
    logic [CLS_W-1:0]  class_q, class_d;
    logic [FEAT_W-1:0] probe_q, probe_d;
    logic [FEAT_W:0]   cnt_q, cnt_d;
    rsp_t              rsp_q, rsp_d;
    logic [FEAT_W:0]   cnt_inc_s;

    // Next-state logic: request accept, per-cycle compare with priority
    // match > exhaustion > abort > advance, and response handshake.
    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        probe_d   = probe_q;
        cnt_d     = cnt_q;
        rsp_d     = rsp_q;
        cnt_inc_s = cnt_q + (FEAT_W+1)'(1);
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    class_d = bus.req_class_i;
                    probe_d = bus.req_start_i;
                    cnt_d   = {(FEAT_W+1){1'b0}};
                    state_d = SEARCH;
                end else begin
                    state_d = IDLE;
                end
            end
            SEARCH: begin
                if (probe_class_i == class_q) begin
                    rsp_d.found  = 1'b1;
                    rsp_d.vec    = probe_q;
                    rsp_d.probes = cnt_inc_s;
                    state_d      = RESP;
                end else if (cnt_inc_s == SPACE_CNT) begin
                    rsp_d.found  = 1'b0;
                    rsp_d.vec    = probe_q;
                    rsp_d.probes = SPACE_CNT;
                    state_d      = RESP;
                end else if (bus.abort_i) begin
                    rsp_d.found  = 1'b0;
                    rsp_d.vec    = probe_q;
                    rsp_d.probes = cnt_inc_s;
                    state_d      = RESP;
                end else begin
                    // Natural FEAT_W-bit overflow gives the wrap to zero.
                    probe_d = probe_q + FEAT_W'(1);
                    cnt_d   = cnt_inc_s;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            class_q <= {CLS_W{1'b0}};
            probe_q <= {FEAT_W{1'b0}};
            cnt_q   <= {(FEAT_W+1){1'b0}};
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            probe_q <= probe_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
        end
    end

    // Outputs come straight from flops or a decode of the state flop.
    assign probe_o          = probe_q;
    assign busy_o           = (state_q != IDLE);
    assign bus.req_ready_o  = (state_q == IDLE);
    assign bus.rsp_valid_o  = (state_q == RESP);
    assign bus.rsp_found_o  = rsp_q.found;
    assign bus.rsp_vec_o    = rsp_q.vec;
    assign bus.rsp_probes_o = rsp_q.probes;

endmodule
